// File: rtl/matrix_serializer_if.sv
// Handshake bundle for matrix_serializer: matrix load side, pixel stream side and status.
// The slave modport is the serializer's view; master is the surrounding logic's view.
interface matrix_serializer_if;
    localparam int unsigned MatrixW = 72;
    localparam int unsigned PixelW  = 8;
    localparam int unsigned IndexW  = 4;
    localparam int unsigned CountW  = 8;

    logic               matrix_valid;
    logic [MatrixW-1:0] matrix;
    logic               matrix_ready;
    logic               out_ready;
    logic [PixelW-1:0]  pixel;
    logic               pixel_valid;
    logic [IndexW-1:0]  pixel_index;
    logic               pixel_last;
    logic               done;
    logic [CountW-1:0]  matrix_count;

    modport slave (
        input  matrix_valid,
        input  matrix,
        input  out_ready,
        output matrix_ready,
        output pixel,
        output pixel_valid,
        output pixel_index,
        output pixel_last,
        output done,
        output matrix_count
    );

    modport master (
        output matrix_valid,
        output matrix,
        output out_ready,
        input  matrix_ready,
        input  pixel,
        input  pixel_valid,
        input  pixel_index,
        input  pixel_last,
        input  done,
        input  matrix_count
    );
endinterface

// File: rtl/matrix_serializer.sv
// Serializes a packed 3x3 window of 8-bit pixels into a stream s1..s9, one pixel per
// accepted beat, and counts completed windows for the frame controller.
module matrix_serializer (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    matrix_serializer_if.slave   bus
);
    localparam int unsigned MatrixW = 72;
    localparam int unsigned PixelW  = 8;
    localparam int unsigned IndexW  = 4;
    localparam int unsigned CountW  = 8;
    localparam logic [IndexW-1:0] FirstIdx = 4'd1;
    localparam logic [IndexW-1:0] LastIdx  = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [MatrixW-1:0]  hold_q, hold_d;
    logic [IndexW-1:0]   index_q, index_d;
    logic [PixelW-1:0]   pixel_q, pixel_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic                pixel_last_q, pixel_last_d;
    logic                done_q, done_d;
    logic [CountW-1:0]   count_q, count_d;
    logic                matrix_ready_c;
    logic                index_legal_c;

    // Byte select: index 1 is the most significant byte (s1), index 9 the least (s9).
    function automatic logic [PixelW-1:0] sel_byte(input logic [MatrixW-1:0] m,
                                                   input logic [IndexW-1:0]  idx);
        logic [PixelW-1:0] b;
        b = '0;
        case (idx)
            4'd1:    b = m[71:64];
            4'd2:    b = m[63:56];
            4'd3:    b = m[55:48];
            4'd4:    b = m[47:40];
            4'd5:    b = m[39:32];
            4'd6:    b = m[31:24];
            4'd7:    b = m[23:16];
            4'd8:    b = m[15:8];
            4'd9:    b = m[7:0];
            default: b = '0;
        endcase
        return b;
    endfunction

    // Ready depends only on state and clear so upstream never sees a loop through valid.
    assign matrix_ready_c = (state_q == IDLE) && !clear;
    assign index_legal_c  = (index_q >= FirstIdx) && (index_q <= LastIdx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            index_q       <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            pixel_last_q  <= 1'b0;
            done_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            index_q       <= index_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_last_q  <= pixel_last_d;
            done_q        <= done_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        index_d       = index_q;
        pixel_d       = pixel_q;
        pixel_valid_d = pixel_valid_q;
        pixel_last_d  = pixel_last_q;
        done_d        = 1'b0;
        count_d       = count_q;

        if (clear) begin
            // Abort: drop the in-flight window without a done pulse or count update.
            state_d       = IDLE;
            index_d       = '0;
            pixel_d       = '0;
            pixel_valid_d = 1'b0;
            pixel_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.matrix_valid && matrix_ready_c) begin
                        state_d       = SEND;
                        hold_d        = bus.matrix;
                        index_d       = FirstIdx;
                        pixel_d       = sel_byte(bus.matrix, FirstIdx);
                        pixel_valid_d = 1'b1;
                        pixel_last_d  = 1'b0;
                    end
                end
                SEND: begin
                    if (!index_legal_c) begin
                        state_d       = IDLE;
                        index_d       = '0;
                        pixel_d       = '0;
                        pixel_valid_d = 1'b0;
                        pixel_last_d  = 1'b0;
                    end else if (bus.out_ready) begin
                        if (index_q == LastIdx) begin
                            state_d       = IDLE;
                            index_d       = '0;
                            pixel_d       = '0;
                            pixel_valid_d = 1'b0;
                            pixel_last_d  = 1'b0;
                            done_d        = 1'b1;
                            count_d       = count_q + CountW'(1);
                        end else begin
                            index_d      = index_q + IndexW'(1);
                            pixel_d      = sel_byte(hold_q, index_q + IndexW'(1));
                            pixel_last_d = ((index_q + IndexW'(1)) == LastIdx);
                        end
                    end
                end
                default: begin
                    state_d       = IDLE;
                    index_d       = '0;
                    pixel_d       = '0;
                    pixel_valid_d = 1'b0;
                    pixel_last_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.matrix_ready = matrix_ready_c;
    assign bus.pixel        = pixel_q;
    assign bus.pixel_valid  = pixel_valid_q;
    assign bus.pixel_index  = index_q;
    assign bus.pixel_last   = pixel_last_q;
    assign bus.done         = done_q;
    assign bus.matrix_count = count_q;
endmodule

// File: tb/tb_matrix_serializer.sv
// Scoreboard bench for matrix_serializer: a window-level model predicts the pixel stream,
// ready, done and count; a negedge monitor compares the DUT against it every cycle.
module tb_matrix_serializer;
    logic clk = 1'b0;
    logic rst;
    logic clear;

    matrix_serializer_if bus_if ();

    matrix_serializer dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic       done_exp = 1'b0;
    logic [7:0] cnt_exp  = 8'd0;
    int         cyc = 0;
    int         last_done = 0;
    int         wrap_dones = 0;
    bit         seen_done = 0;
    bit         wrap_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        logic [71:0] m;
        int          n;
        cyc++;
        n = exp_q.size();
        check("matrix_ready", 32'(bus_if.matrix_ready), 32'(n == 0 && !clear));
        check("pixel_valid",  32'(bus_if.pixel_valid),  32'(n != 0));
        if (n != 0) begin
            check("pixel",       32'(bus_if.pixel),       32'(exp_q[0]));
            check("pixel_index", 32'(bus_if.pixel_index), 32'(10 - n));
            check("pixel_last",  32'(bus_if.pixel_last),  32'(n == 1));
        end else begin
            check("idle_pixel",       32'(bus_if.pixel),       32'd0);
            check("idle_pixel_index", 32'(bus_if.pixel_index), 32'd0);
            check("idle_pixel_last",  32'(bus_if.pixel_last),  32'd0);
        end
        check("done",         32'(bus_if.done),         32'(done_exp));
        check("matrix_count", 32'(bus_if.matrix_count), 32'(cnt_exp));

        if (wrap_phase && bus_if.done) begin
            if (seen_done) check("done_gap", 32'(cyc - last_done), 32'd10);
            seen_done = 1;
            last_done = cyc;
            wrap_dones++;
        end

        done_exp = 1'b0;
        if (rst) begin
            exp_q.delete();
            cnt_exp = 8'd0;
        end else if (clear) begin
            exp_q.delete();
        end else if (n != 0) begin
            if (bus_if.out_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    done_exp = 1'b1;
                    cnt_exp  = cnt_exp + 8'd1;
                end
            end
        end else if (bus_if.matrix_valid) begin
            m = bus_if.matrix;
            for (int i = 0; i < 9; i++) exp_q.push_back(8'(m >> (8 * (8 - i))));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] rand_matrix();
        return {8'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    initial begin
        rst                 = 1'b1;
        clear               = 1'b0;
        bus_if.matrix_valid = 1'b0;
        bus_if.matrix       = '0;
        bus_if.out_ready    = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Directed load with free-flowing output.
        bus_if.out_ready    = 1'b1;
        bus_if.matrix_valid = 1'b1;
        bus_if.matrix       = 72'h010203040506070809;
        tick();
        bus_if.matrix_valid = 1'b0;
        repeat (11) tick();

        // Backpressure pattern 1,0,0 repeating.
        bus_if.matrix_valid = 1'b1;
        bus_if.matrix       = rand_matrix();
        bus_if.out_ready    = 1'b1;
        tick();
        bus_if.matrix_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus_if.out_ready = (i % 3 == 0);
            tick();
        end
        bus_if.out_ready = 1'b1;
        repeat (3) tick();

        // Second matrix presented while busy.
        bus_if.matrix_valid = 1'b1;
        bus_if.matrix       = rand_matrix();
        tick();
        bus_if.matrix = rand_matrix();
        repeat (12) tick();
        bus_if.matrix_valid = 1'b0;
        repeat (12) tick();

        // Clear while pixel_index is 4.
        bus_if.matrix_valid = 1'b1;
        bus_if.matrix       = rand_matrix();
        tick();
        bus_if.matrix_valid = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        bus_if.matrix_valid = 1'b1;
        bus_if.matrix       = rand_matrix();
        tick();
        bus_if.matrix_valid = 1'b0;
        repeat (11) tick();

        // Clear together with load in IDLE, then load the next cycle.
        clear               = 1'b1;
        bus_if.matrix_valid = 1'b1;
        bus_if.matrix       = rand_matrix();
        tick();
        clear         = 1'b0;
        bus_if.matrix = rand_matrix();
        tick();
        bus_if.matrix_valid = 1'b0;
        repeat (11) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus_if.matrix_valid = 1'($urandom_range(0, 1));
            bus_if.matrix       = rand_matrix();
            bus_if.out_ready    = ($urandom_range(0, 3) != 0);
            clear               = ($urandom_range(0, 19) == 0);
            tick();
        end
        clear               = 1'b0;
        bus_if.matrix_valid = 1'b0;
        bus_if.out_ready    = 1'b1;
        repeat (12) tick();

        // 256+ back-to-back matrices to wrap the count.
        wrap_phase          = 1;
        bus_if.matrix_valid = 1'b1;
        for (int i = 0; i < 2575; i++) begin
            bus_if.matrix = rand_matrix();
            tick();
        end
        bus_if.matrix_valid = 1'b0;
        repeat (12) tick();
        wrap_phase = 0;
        check("wrap_done_count", 32'(wrap_dones >= 257), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
